// File: rtl/oddr_xn_ser.sv
// oddr_xn_ser: multi-lane DDR output serializer (4:1 or 8:1 gearing).
// Each lane captures a GEAR-bit word on SCLK and shifts it out two bits per
// ECLK cycle, bit 0 first, on the high/low halves of ECLK. ALIGN slips the
// word boundary later by one ECLK cycle (two bits) per sampled-high cycle.
// Optional feature macro: ODDR_XN_SER_TRISTATE_EN adds TS/QT output-enable
// control that travels with each word.
module oddr_xn_ser #(
    parameter int LANES = 1,
    parameter int GEAR  = 4,
    localparam int PW   = (GEAR > 4) ? 2 : 1
) (
    input  logic                   ECLK,
    input  logic                   SCLK,
    input  logic                   RSTB,
    input  logic [LANES*GEAR-1:0]  D,
    input  logic                   ALIGN,
`ifdef ODDR_XN_SER_TRISTATE_EN
    input  logic [LANES-1:0]       TS,
    output logic [LANES-1:0]       QT,
`endif
    output logic [LANES-1:0]       Q,
    output logic [PW-1:0]          PHASE
);

    localparam logic [PW-1:0] PH_LAST = PW'(GEAR/2 - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);

    generate
        if (GEAR != 4 && GEAR != 8) begin : g_bad_gear
            $fatal(1, "oddr_xn_ser: GEAR must be 4 or 8");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $fatal(1, "oddr_xn_ser: LANES must be 1..16");
        end
    endgenerate

    logic [LANES*GEAR-1:0] t_word;
    logic [PW-1:0]         ph;
    logic [GEAR-1:0]       s_reg [LANES];
    logic [LANES-1:0]      r_bit;
    logic [LANES-1:0]      fp_bit;
    logic [LANES-1:0]      f_bit;
    logic                  load;

    // A slip cycle postpones the load by one ECLK cycle.
    assign load = (ph == PH_LAST) && !ALIGN;

    // Capture the parallel word in the SCLK domain.
    always_ff @(posedge SCLK) begin
        if (RSTB) t_word <= '0;
        else      t_word <= D;
    end

    // Phase counter and slip count. ph sits at 0 through reset, so the first
    // SCLK rise that samples RSTB low is the one that frames words.
    always_ff @(posedge ECLK) begin
        if (RSTB) begin
            ph    <= '0;
            PHASE <= '0;
        end else if (ALIGN) begin
            PHASE <= PHASE + PH_ONE;
        end else begin
            ph <= ph + PH_ONE;
        end
    end

    // Per-lane shift register and rising-edge output stage.
    always_ff @(posedge ECLK) begin
        if (RSTB) begin
            for (int l = 0; l < LANES; l++) s_reg[l] <= '0;
            r_bit  <= '0;
            fp_bit <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (load) s_reg[l] <= t_word[l*GEAR +: GEAR];
                else      s_reg[l] <= {2'b00, s_reg[l][GEAR-1:2]};
                r_bit[l]  <= s_reg[l][0];
                fp_bit[l] <= s_reg[l][1];
            end
        end
    end

    // Odd bit retimed onto the falling edge for the low half of ECLK.
    always_ff @(negedge ECLK) begin
        if (RSTB) f_bit <= '0;
        else      f_bit <= fp_bit;
    end

    // DDR mux; an unknown ECLK yields R only where R and F agree.
    assign Q = ECLK ? r_bit : f_bit;

`ifdef ODDR_XN_SER_TRISTATE_EN
    logic [LANES-1:0] ts_cap;
    logic [LANES-1:0] ts_word;
    logic             load_d;

    // Capture TS together with its data word; reset to high-Z.
    always_ff @(posedge SCLK) begin
        if (RSTB) ts_cap <= '1;
        else      ts_cap <= TS;
    end

    // TS rides with its word and reaches QT on the edge that drives bit 0.
    always_ff @(posedge ECLK) begin
        if (RSTB) begin
            ts_word <= '1;
            load_d  <= 1'b0;
            QT      <= '1;
        end else begin
            if (load) ts_word <= ts_cap;
            load_d <= load;
            if (load_d) QT <= ts_word;
        end
    end
`endif

endmodule

// File: tb/tb_oddr_xn_ser.sv
// Directed bench for oddr_xn_ser: a 4:1 single-lane instance and an 8:1
// two-lane instance share ECLK. Word streams are table driven; slip, reset
// and tristate cases are hand-written sequences.
module tb_oddr_xn_ser;

    logic        eclk, sclk4, sclk8;
    int          ecnt;
    int          cur_k;

    logic        rstb4, align4;
    logic [3:0]  d4;
    logic        q4;
    logic        phase4;

    logic        rstb8, align8;
    logic [15:0] d8;
    logic [1:0]  q8;
    logic [1:0]  phase8;

    logic        q4_hi, q4_lo, ph4_hi;
    logic [1:0]  q8_hi, q8_lo, ph8_hi;

`ifdef ODDR_XN_SER_TRISTATE_EN
    logic        ts4, qt4, qt4_hi;
    logic [1:0]  ts8, qt8, qt8_hi;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    oddr_xn_ser #(.LANES(1), .GEAR(4)) dut4 (
        .ECLK (eclk),
        .SCLK (sclk4),
        .RSTB (rstb4),
        .D    (d4),
        .ALIGN(align4),
`ifdef ODDR_XN_SER_TRISTATE_EN
        .TS   (ts4),
        .QT   (qt4),
`endif
        .Q    (q4),
        .PHASE(phase4)
    );

    oddr_xn_ser #(.LANES(2), .GEAR(8)) dut8 (
        .ECLK (eclk),
        .SCLK (sclk8),
        .RSTB (rstb8),
        .D    (d8),
        .ALIGN(align8),
`ifdef ODDR_XN_SER_TRISTATE_EN
        .TS   (ts8),
        .QT   (qt8),
`endif
        .Q    (q8),
        .PHASE(phase8)
    );

    // ECLK period 10; rise k at time 10k+5. SCLK rises coincide with ECLK rises.
    initial begin
        eclk = 0; sclk4 = 0; sclk8 = 0; ecnt = 0;
        forever begin
            #5;
            eclk  = 1;
            sclk4 = (ecnt % 2) == 0;
            sclk8 = (ecnt % 4) < 2;
            #5;
            eclk = 0;
            ecnt++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One ECLK cycle: sample high half after the rise, low half after the fall.
    task automatic tick();
        @(posedge eclk);
        cur_k = ecnt;
        #3;
        q4_hi  = q4;
        q8_hi  = q8;
        ph4_hi = phase4;
        ph8_hi = phase8;
`ifdef ODDR_XN_SER_TRISTATE_EN
        qt4_hi = qt4;
        qt8_hi = qt8;
`endif
        @(negedge eclk);
        #3;
        q4_lo = q4;
        q8_lo = q8;
    endtask

    // Returns after the ECLK cycle just before a common SCLK rise.
    task automatic wait_pre_sclk();
        do tick(); while ((cur_k % 4) != 3);
    endtask

    typedef struct {
        logic [3:0] d;
        logic [3:0] seq;
    } vec4_t;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  seq0;
        logic [7:0]  seq1;
    } vec8_t;

    vec4_t       v4 [7];
    vec8_t       v8 [4];
    logic [3:0]  obs4;
    logic [7:0]  o0, o1;
    logic [23:0] s0, s1, s4;
    logic [1:0]  acc;
`ifdef ODDR_XN_SER_TRISTATE_EN
    logic [7:0]  oqt;
`endif

    initial begin
        // Expected sequences are written first-transmitted bit on the left.
        v4[0] = '{4'b1011, 4'b1101};
        v4[1] = '{4'b1011, 4'b1101};
        v4[2] = '{4'b1011, 4'b1101};
        v4[3] = '{4'b0001, 4'b1000};
        v4[4] = '{4'b1000, 4'b0001};
        v4[5] = '{4'b0110, 4'b0110};
        v4[6] = '{4'b1100, 4'b0011};
        v8[0] = '{16'h3CA5, 8'hA5, 8'h3C};
        v8[1] = '{16'h8001, 8'h80, 8'h01};
        v8[2] = '{16'h12C1, 8'h83, 8'h48};
        v8[3] = '{16'h00FF, 8'hFF, 8'h00};

        rstb4 = 1; rstb8 = 1; align4 = 1; align8 = 1;
        d4 = 4'hF; d8 = 16'hFFFF;
`ifdef ODDR_XN_SER_TRISTATE_EN
        ts4 = 1'b0; ts8 = 2'b00;
`endif

        // Reset state, with ALIGN and data active to show they are ignored.
        repeat (6) tick();
        chk("reset q4 high half", 32'(q4_hi), 32'd0);
        chk("reset q4 low half", 32'(q4_lo), 32'd0);
        chk("reset q8 high half", 32'(q8_hi), 32'd0);
        chk("reset q8 low half", 32'(q8_lo), 32'd0);
        chk("reset phase4 with align", 32'(ph4_hi), 32'd0);
        chk("reset phase8 with align", 32'(ph8_hi), 32'd0);
`ifdef ODDR_XN_SER_TRISTATE_EN
        chk("reset qt4", 32'(qt4_hi), 32'd1);
        chk("reset qt8", 32'(qt8_hi), 32'd3);
        ts4 = 1'b1; ts8 = 2'b11;
`endif
        align4 = 0; align8 = 0;

        // GEAR=4 word stream: two-cycle latency, back-to-back words.
        wait_pre_sclk();
        d4 = v4[0].d; rstb4 = 0;
        for (int j = 0; j <= 7; j++) begin
            obs4 = '0;
            for (int c = 0; c < 2; c++) begin
                tick();
                obs4 = {obs4[1:0], q4_hi, q4_lo};
            end
            if (j == 0) chk("q4 zero before first word", 32'(obs4), 32'd0);
            else        chk($sformatf("q4 word %0d", j - 1), 32'(obs4), 32'(v4[j-1].seq));
            d4 = (j + 1 < 7) ? v4[j+1].d : 4'h0;
        end

        // GEAR=4 slips: pulse at a load cycle (PHASE 0->1), then a non-load cycle (1->0).
        rstb4 = 1;
        repeat (4) tick();
        wait_pre_sclk();
        d4 = 4'b1011; rstb4 = 0; s4 = '0;
        for (int r = 0; r <= 16; r++) begin
            tick();
            if (r >= 5) s4 = {s4[21:0], q4_hi, q4_lo};
            if (r == 5)  chk("phase4 after first slip", 32'(ph4_hi), 32'd1);
            if (r == 10) chk("phase4 held between slips", 32'(ph4_hi), 32'd1);
            if (r == 11) chk("phase4 after second slip", 32'(ph4_hi), 32'd0);
            align4 = (r == 4 || r == 10);
        end
        chk("q4 stream across slips", 32'(s4), 32'h4DDD37);
        rstb4 = 1;

`ifdef ODDR_XN_SER_TRISTATE_EN
        // TS low for one word only: QT low for its four bit times.
        repeat (4) tick();
        wait_pre_sclk();
        d4 = 4'b1011; ts4 = 1'b1; rstb4 = 0; oqt = '0;
        for (int r = 0; r <= 7; r++) begin
            tick();
            oqt = {oqt[6:0], qt4_hi};
            ts4 = (r == 1) ? 1'b0 : 1'b1;
        end
        chk("qt4 window for one word", 32'(oqt), 32'hF3);
        rstb4 = 1;
`endif

        // GEAR=8 two-lane word stream: four-cycle latency, lanes bit-aligned.
        wait_pre_sclk();
        d8 = v8[0].d; rstb8 = 0;
        for (int j = 0; j <= 4; j++) begin
            o0 = '0; o1 = '0;
            for (int c = 0; c < 4; c++) begin
                tick();
                o0 = {o0[5:0], q8_hi[0], q8_lo[0]};
                o1 = {o1[5:0], q8_hi[1], q8_lo[1]};
            end
            if (j == 0) begin
                chk("q8 lane0 zero before first word", 32'(o0), 32'd0);
                chk("q8 lane1 zero before first word", 32'(o1), 32'd0);
            end else begin
                chk($sformatf("q8 lane0 word %0d", j - 1), 32'(o0), 32'(v8[j-1].seq0));
                chk($sformatf("q8 lane1 word %0d", j - 1), 32'(o1), 32'(v8[j-1].seq1));
            end
            d8 = (j + 1 < 4) ? v8[j+1].d : 16'h0;
        end
        rstb8 = 1;

        // GEAR=8 three back-to-back slips: six zero bits, PHASE ends at 3.
        repeat (4) tick();
        wait_pre_sclk();
        d8 = 16'h0FFF; rstb8 = 0; s0 = '0; s1 = '0;
        for (int r = 0; r <= 19; r++) begin
            tick();
            if (r >= 8) begin
                s0 = {s0[21:0], q8_hi[0], q8_lo[0]};
                s1 = {s1[21:0], q8_hi[1], q8_lo[1]};
            end
            if (r == 11) chk("phase8 after first slip", 32'(ph8_hi), 32'd1);
            if (r == 13) chk("phase8 after third slip", 32'(ph8_hi), 32'd3);
            if (r == 19) chk("phase8 held after slips", 32'(ph8_hi), 32'd3);
            align8 = (r >= 10 && r <= 12);
        end
        chk("q8 lane0 stream across slips", 32'(s0), 32'hFF03FF);
        chk("q8 lane1 stream across slips", 32'(s1), 32'hF003C3);
        rstb8 = 1;

        // GEAR=8 reset mid-word with all-ones data.
        repeat (4) tick();
        wait_pre_sclk();
        d8 = 16'hFFFF; rstb8 = 0;
        for (int r = 0; r <= 5; r++) tick();
        chk("q8 ones before mid-word reset", 32'(q8_hi), 32'd3);
        rstb8 = 1;
        tick();
        chk("q8 first fall after reset", 32'(q8_lo), 32'd0);
        acc = q8_lo;
        repeat (4) begin
            tick();
            acc = acc | q8_hi | q8_lo;
        end
        while ((cur_k % 4) != 3) begin
            tick();
            acc = acc | q8_hi | q8_lo;
        end
        rstb8 = 0;
        for (int r = 0; r < 4; r++) begin
            tick();
            acc = acc | q8_hi | q8_lo;
        end
        chk("q8 no residual ones around reset", 32'(acc), 32'd0);
        tick();
        chk("q8 first word after reset", 32'(q8_hi), 32'd3);
        rstb8 = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
